// File: rtl/qupls4_wb_arbiter.sv
// Qupls4 write-back arbiter: per-FU result FIFOs drained onto the four
// register-file write ports in round-robin order, with registered port outputs.
module qupls4_wb_arbiter #(
    parameter int NFU  = 8,
    parameter int FDEP = 4,
    parameter int VWID = 64,
    parameter int FWID = 8,
    parameter int PRW  = 10,
    parameter int WEW  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NFU-1:0]           fu_valid,
    output logic [NFU-1:0]           fu_ready,
    input  logic [NFU-1:0][PRW-1:0]  fu_pr,
    input  logic [NFU-1:0][VWID-1:0] fu_val,
    input  logic [NFU-1:0][FWID-1:0] fu_flags,
    input  logic [NFU-1:0][WEW-1:0]  fu_we,
    output logic [3:0]               wr,
    output logic [3:0][WEW-1:0]      we,
    output logic [3:0][PRW-1:0]      wa,
    output logic [3:0][VWID-1:0]     wi,
    output logic [3:0][FWID-1:0]     wti,
    output logic                     pend
);
    localparam int NPORT = 4;
    localparam int PTRW  = $clog2(FDEP);
    localparam int CNTW  = $clog2(FDEP + 1);
    localparam int RRW   = (NFU > 1) ? $clog2(NFU) : 1;

    typedef struct packed {
        logic [PRW-1:0]  pr;
        logic [VWID-1:0] val;
        logic [FWID-1:0] flags;
        logic [WEW-1:0]  we;
    } entry_t;

    entry_t          fifo_mem [NFU][FDEP];
    entry_t          head     [NFU];
    logic [PTRW-1:0] rd_ptr_q [NFU];
    logic [PTRW-1:0] rd_ptr_d [NFU];
    logic [PTRW-1:0] wr_ptr_q [NFU];
    logic [PTRW-1:0] wr_ptr_d [NFU];
    logic [CNTW-1:0] cnt_q    [NFU];
    logic [CNTW-1:0] cnt_d    [NFU];
    logic [RRW-1:0]  rr_q, rr_d;
    logic [RRW-1:0]  sel      [NPORT];
    logic [NFU-1:0]  push, pop;

    logic [3:0]            wr_q, wr_d;
    logic [3:0][WEW-1:0]   we_q, we_d;
    logic [3:0][PRW-1:0]   wa_q, wa_d;
    logic [3:0][VWID-1:0]  wi_q, wi_d;
    logic [3:0][FWID-1:0]  wti_q, wti_d;
    logic                  pend_q, pend_d;

    // Round-robin scan from rr: the first four non-empty FIFOs take ports 0..3.
    always_comb begin
        int n;
        int f;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        pop  = '0;
        wr_d = '0;
        rr_d = rr_q;
        n    = 0;
        f    = 0;
        for (int k = 0; k < NPORT; k++) sel[k] = '0;
        for (int i = 0; i < NFU; i++) begin
            f = (int'(rr_q) + i) % NFU;
            if (n < NPORT && cnt_q[f] != '0) begin
                pop[f]  = 1'b1;
                wr_d[n] = 1'b1;
                sel[n]  = RRW'(f);
                rr_d    = RRW'((f + 1) % NFU);
                n++;
            end
        end
    end

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        pend_d = 1'b0;
        for (int f = 0; f < NFU; f++) begin
            fu_ready[f] = !rst && (cnt_q[f] != CNTW'(FDEP));
            push[f]     = fu_valid[f] && fu_ready[f] && (fu_pr[f] != '0);
            cnt_d[f]    = cnt_q[f] + CNTW'(push[f]) - CNTW'(pop[f]);
            wr_ptr_d[f] = push[f] ? wr_ptr_q[f] + PTRW'(1) : wr_ptr_q[f];
            rd_ptr_d[f] = pop[f]  ? rd_ptr_q[f] + PTRW'(1) : rd_ptr_q[f];
            head[f]     = fifo_mem[f][rd_ptr_q[f]];
            pend_d      = pend_d | (cnt_d[f] != '0);
        end
    end

    // Unused ports keep their old fields; only wr qualifies them.
    always_comb begin
        we_d  = we_q;
        wa_d  = wa_q;
        wi_d  = wi_q;
        wti_d = wti_q;
        for (int k = 0; k < NPORT; k++) begin
            if (wr_d[k]) begin
                we_d[k]  = head[sel[k]].we;
                wa_d[k]  = head[sel[k]].pr;
                wi_d[k]  = head[sel[k]].val;
                wti_d[k] = head[sel[k]].flags;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NFU; f++) begin
                cnt_q[f]    <= '0;
                rd_ptr_q[f] <= '0;
                wr_ptr_q[f] <= '0;
            end
            rr_q   <= '0;
            wr_q   <= '0;
            we_q   <= '0;
            wa_q   <= '0;
            wi_q   <= '0;
            wti_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_q     <= rr_d;
            wr_q     <= wr_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wi_q     <= wi_d;
            wti_q    <= wti_d;
            pend_q   <= pend_d;
        end
    end

    // NOTE: storage is not reset; the cleared counts already mark every slot empty.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NFU; f++) begin
            if (push[f]) fifo_mem[f][wr_ptr_q[f]] <= '{fu_pr[f], fu_val[f], fu_flags[f], fu_we[f]};
        end
    end

    assign wr   = wr_q;
    assign we   = we_q;
    assign wa   = wa_q;
    assign wi   = wi_q;
    assign wti  = wti_q;
    assign pend = pend_q;

endmodule
